pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_ctrl_sat_counter.sv | 23 ++
 rtl/pipe_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared types and defaults for the pipeline controller.
//   pipe_state_e : controller FSM state (RUN, MDU_BUSY, MDU_DONE)
//   REG_W_DEF    : default register-index width
//   CNT_W_DEF    : default performance-counter width
package pipe_ctrl_pkg;

  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_BUSY = 2'd1,
    ST_MDU_DONE = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter -- saturating up-counter with synchronous clear.
//   clk : clock, posedge
//   clr : synchronous clear (wins over inc)
//   inc : count enable, +1 per cycle until all-ones
//   cnt : current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- stall/flush/bubble controller for a five-stage pipeline.
//   clk, rst_n              : clock (posedge), synchronous active-low reset
//   id_rs1/id_rs2, id_use*  : ID-stage source indices and read flags
//   ex_rd, ex_is_load       : EX destination and load flag (load-use hazard)
//   ex_redirect             : EX resolved a taken/mispredicted transfer
//   ex_mdu_op, mdu_done     : multi-cycle mul/div in EX, completion pulse
//   mem_req, mem_ready      : MEM access and data-memory acceptance
//   *_en                    : pipeline-register enables
//   ifid_flush              : flush IF/ID
//   id/ex/mem_bubble        : insert NOP into ID/EX, EX/MEM, MEM/WB
//   mdu_go                  : one-cycle MDU start pulse
//   stall_cnt, redirect_cnt : saturating performance counters
//   dbg_state               : controller FSM state (debug)
//
// Handshake: a MEM access completes in the cycle mem_req & mem_ready are both
// high; while mem_req is high and mem_ready low the whole pipeline up to MEM
// holds and MEM/WB receives a NOP. mem_req must stay high until accepted.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             ex_mdu_op,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             id_bubble,
  output logic             ex_bubble,
  output logic             mem_bubble,
  output logic             mdu_go,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [1:0]       dbg_state
);

  pipe_state_e state_q, state_d, cur_state;
  logic        mem_stall;
  logic        load_use;
  logic        redirect_act;

  assign mem_stall = mem_req & ~mem_ready;

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_use1 && (id_rs1 == ex_rd)) ||
                     (id_use2 && (id_rs2 == ex_rd)));

  // While in reset the outputs are decoded as if in RUN.
  assign cur_state = rst_n ? state_q : ST_RUN;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    id_bubble    = 1'b0;
    ex_bubble    = 1'b0;
    mem_bubble   = 1'b0;
    mdu_go       = 1'b0;
    redirect_act = 1'b0;
    state_d      = state_q;

    if (mem_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      mem_bubble = 1'b1;
      // Remember a completion that lands during a MEM wait.
      if (cur_state == ST_MDU_BUSY && mdu_done) begin
        state_d = ST_MDU_DONE;
      end
    end else begin
      case (cur_state)
        ST_RUN: begin
          if (ex_mdu_op) begin
            mdu_go    = rst_n;
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            ex_bubble = 1'b1;
            state_d   = ST_MDU_BUSY;
          end else if (ex_redirect) begin
            ifid_flush   = 1'b1;
            redirect_act = 1'b1;
          end else if (load_use) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            id_bubble = 1'b1;
          end
        end
        ST_MDU_BUSY: begin
          if (mdu_done) begin
            // Release: everything advances; leaving RUN-decode here keeps the
            // still-present MDU op from issuing a second mdu_go.
            state_d = ST_RUN;
          end else begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            ex_bubble = 1'b1;
          end
        end
        ST_MDU_DONE: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (!rst_n),
    .inc (!pc_en),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk (clk),
    .clr (!rst_n),
    .inc (redirect_act),
    .cnt (redirect_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed bench for pipe_ctrl (small counters to reach saturation).
module tb_pipe_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  // Control vector {pc,ifid,idex,exmem,memwb, flush,id_b,ex_b,mem_b, go}
  localparam logic [9:0] C_IDLE  = 10'b11111_0000_0;
  localparam logic [9:0] C_MEMST = 10'b00001_0001_0;
  localparam logic [9:0] C_GO    = 10'b00011_0010_1;
  localparam logic [9:0] C_HOLD  = 10'b00011_0010_0;
  localparam logic [9:0] C_REDIR = 10'b11111_1000_0;
  localparam logic [9:0] C_LU    = 10'b00111_0100_0;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use1, id_use2, ex_is_load, ex_redirect;
  logic             ex_mdu_op, mdu_done, mem_req, mem_ready;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, id_bubble, ex_bubble, mem_bubble, mdu_go;
  logic [CNT_W-1:0] stall_cnt, redirect_cnt;
  logic [1:0]       dbg_state;
  logic [9:0]       ctl;

  int n_checks = 0;
  int n_errors = 0;
  int go_n;
  logic [9:0] exp_q[$];

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, id_bubble, ex_bubble, mem_bubble, mdu_go};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipe_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .ex_mdu_op(ex_mdu_op), .mdu_done(mdu_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .id_bubble(id_bubble), .ex_bubble(ex_bubble), .mem_bubble(mem_bubble),
    .mdu_go(mdu_go), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use1 = 1'b0; id_use2 = 1'b0;
    ex_rd = '0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    ex_mdu_op = 1'b0; mdu_done = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_load_use(input logic [REG_W-1:0] rd);
    ex_is_load = 1'b1; ex_rd = rd;
    id_rs1 = 5'd3; id_use1 = 1'b1;
    id_rs2 = rd;   id_use2 = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_ctl", {22'd0, ctl}, {22'd0, C_IDLE});
    tick();
    check("reset_state", {30'd0, dbg_state}, {30'd0, S_RUN});
    check("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    check("reset_redir_cnt", {28'd0, redirect_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ctl", {22'd0, ctl}, {22'd0, C_IDLE});
    tick();

    // ---- load-use on rs2 ----
    set_load_use(5'd5);
    @(negedge clk);
    check("lu_ctl", {22'd0, ctl}, {22'd0, C_LU});
    tick();
    idle_inputs();
    @(negedge clk);
    check("lu_after_ctl", {22'd0, ctl}, {22'd0, C_IDLE});
    check("lu_stall_cnt", {28'd0, stall_cnt}, 32'd1);

    // ---- load to x0: no hazard; unused matching source: no hazard ----
    do_reset();
    set_load_use(5'd0);
    id_rs1 = 5'd0;
    @(negedge clk);
    check("lu_x0_ctl", {22'd0, ctl}, {22'd0, C_IDLE});
    tick();
    check("lu_x0_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    set_load_use(5'd7);
    id_use2 = 1'b0;
    @(negedge clk);
    check("lu_unused_ctl", {22'd0, ctl}, {22'd0, C_IDLE});
    tick();
    idle_inputs();

    // ---- MDU, done after 8 cycles ----
    do_reset();
    exp_q.push_back(C_GO);
    for (int i = 0; i < 7; i++) exp_q.push_back(C_HOLD);
    exp_q.push_back(C_IDLE);
    go_n = 0;
    ex_mdu_op = 1'b1;
    for (int c = 0; c < 9; c++) begin
      mdu_done = (c == 8);
      @(negedge clk);
      if (exp_q.size() > 0) check($sformatf("mdu_ctl_c%0d", c), {22'd0, ctl}, {22'd0, exp_q.pop_front()});
      if (c == 4) check("mdu_busy_state", {30'd0, dbg_state}, {30'd0, S_BUSY});
      if (mdu_go) go_n++;
      tick();
    end
    idle_inputs();
    check("mdu_go_pulses", go_n, 32'd1);
    check("mdu_exit_state", {30'd0, dbg_state}, {30'd0, S_RUN});
    check("mdu_stall_cnt", {28'd0, stall_cnt}, 32'd8);

    // ---- MDU done coincident with a 3-cycle MEM stall ----
    do_reset();
    ex_mdu_op = 1'b1;
    @(negedge clk);
    check("mdm_go_ctl", {22'd0, ctl}, {22'd0, C_GO});
    tick();
    @(negedge clk);
    check("mdm_hold_ctl", {22'd0, ctl}, {22'd0, C_HOLD});
    tick();
    mdu_done = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    check("mdm_coinc_ctl", {22'd0, ctl}, {22'd0, C_MEMST});
    check("mdm_coinc_state", {30'd0, dbg_state}, {30'd0, S_BUSY});
    tick();
    mdu_done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("mdm_wait_state_%0d", c), {30'd0, dbg_state}, {30'd0, S_DONE});
      check($sformatf("mdm_wait_ctl_%0d", c), {22'd0, ctl}, {22'd0, C_MEMST});
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("mdm_rel_state", {30'd0, dbg_state}, {30'd0, S_DONE});
    check("mdm_rel_ctl", {22'd0, ctl}, {22'd0, C_IDLE});
    tick();
    idle_inputs();
    check("mdm_exit_state", {30'd0, dbg_state}, {30'd0, S_RUN});

    // ---- redirect beats load-use; redirect deferred under MEM stall ----
    do_reset();
    set_load_use(5'd5);
    ex_redirect = 1'b1;
    @(negedge clk);
    check("redir_ctl", {22'd0, ctl}, {22'd0, C_REDIR});
    tick();
    idle_inputs();
    check("redir_cnt_1", {28'd0, redirect_cnt}, 32'd1);
    check("redir_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    ex_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    check("redir_defer_ctl", {22'd0, ctl}, {22'd0, C_MEMST});
    tick();
    check("redir_defer_cnt", {28'd0, redirect_cnt}, 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    check("redir_late_ctl", {22'd0, ctl}, {22'd0, C_REDIR});
    tick();
    idle_inputs();
    check("redir_cnt_2", {28'd0, redirect_cnt}, 32'd2);

    // ---- reset in the middle of MDU_BUSY ----
    do_reset();
    ex_mdu_op = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mdu_ctl", {22'd0, ctl}, {22'd0, C_HOLD});
    check("rst_mdu_pre_state", {30'd0, dbg_state}, {30'd0, S_BUSY});
    tick();
    rst_n = 1'b1;
    ex_mdu_op = 1'b0;
    check("rst_mdu_state", {30'd0, dbg_state}, {30'd0, S_RUN});
    check("rst_mdu_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    // ---- saturation: 20 stall cycles into a 4-bit counter ----
    set_load_use(5'd9);
    for (int c = 0; c < 20; c++) tick();
    check("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
    idle_inputs();
    tick();
    check("sat_hold_cnt", {28'd0, stall_cnt}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
